fadd_sched: RTL
===============

Name: fadd_sched

Overview:
- Sequencer/arbiter that shares one combinational fadd_fsub instance between two requesters: requester 0 is the FP issue path, requester 1 is the FP accumulate/microcode path.
- Accepts requests on valid/ready handshakes and registers the operands.
- Holds the operands and En stable on the unit for EXEC_CYCLES clocks, treating the adder as a multicycle path.
- Captures frd and returns it on a per-requester response handshake.
- Sits between the FP issue logic and the fadd_fsub instance.

Parameters:
- FLEN, 32, operand/result width, passed through to fadd_fsub.
- EXEC_CYCLES, 2, clocks the operands are held on the unit before frd is sampled. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_frs1  in  FLEN  requester 0 operand 1
- req0_frs2  in  FLEN  requester 0 operand 2
- req0_funct  in  1  requester 0 op select: 0 add, 1 sub
- req1_valid / req1_ready / req1_frs1 / req1_frs2 / req1_funct  same as the requester 0 ports, for requester 1
- rsp0_valid  out  1  result pending for requester 0
- rsp0_ready  in  1  requester 0 takes the result
- rsp1_valid  out  1  result pending for requester 1
- rsp1_ready  in  1  requester 1 takes the result
- rsp_frd  out  FLEN  result; shared by both responses, valid only with rspN_valid
- busy  out  1  high whenever state != IDLE
- fu_frs1  out  FLEN  to fadd_fsub frs1
- fu_frs2  out  FLEN  to fadd_fsub frs2
- fu_En  out  1  to fadd_fsub En
- fu_funct  out  1  to fadd_fsub Funct
- fu_frd  in  FLEN  from fadd_fsub frd

Behaviour:
- States: IDLE, EXEC, RESP. Register `owner` (1 bit) records the granted requester.
- Reset, synchronous and checked at every edge in every state:
  - state=IDLE, cnt=0, owner=0, last_grant=1 (so requester 0 wins the first tie).
  - All operand, result and fu_* registers are cleared to 0.
  - All ready/valid outputs are 0 and busy=0.
  - Reset mid-EXEC or mid-RESP drops the operation silently; no response is produced.
- IDLE:
  - reqN_ready is combinational: asserted only for the granted requester, only in IDLE, only when that requester's valid is high.
  - Only one grant per cycle.
  - On a grant, latch frs1/frs2/funct into the fu_* registers, set owner=N, last_grant=N, cnt=EXEC_CYCLES-1, and go to EXEC.
- EXEC:
  - fu_En=1; fu_frs1, fu_frs2 and fu_funct are held constant.
  - Each clock: if cnt==0, register rsp_frd <= fu_frd and go to RESP; otherwise cnt <= cnt-1.
  - Requests are not accepted (ready=0).
- RESP:
  - fu_En=0. rsp<owner>_valid=1; the other rsp valid is 0. rsp_frd is held.
  - When rsp<owner>_ready is high, go to IDLE the next cycle.
  - rspN_ready from the non-owner is ignored.
  - Back-pressure holds RESP indefinitely, with rsp_frd stable.
- Latency: accept edge to rsp_valid high is EXEC_CYCLES+1 clocks. Minimum issue interval per op is EXEC_CYCLES+2 clocks when the responder is always ready.
- fu_En=0 outside EXEC. fu_* operands keep their last values (no toggling).
- busy=1 in EXEC and RESP.
- Arithmetic is pass-through. The block never alters operands or the result; zero/sign handling belongs to fadd_fsub.
- cnt is 4 bits. EXEC_CYCLES=1 means the sample happens on the first EXEC edge.
- A requester that deasserts valid before ready is not granted; no state change.

Optional Feature:
- Macro: FADD_SCHED_RR_EN.
- Defined: round-robin arbitration. On simultaneous valid, grant the requester that is not last_grant. A single valid requester is always granted.
- Undefined: fixed priority, requester 0 always wins ties. last_grant is still maintained but does not affect grants.

Test Plan:
- Add: req0 with frs1=0x3F800000, frs2=0x40000000, funct=0; EXEC_CYCLES=2 -> req0_ready the same cycle; rsp0_valid 3 clocks later with rsp_frd=0x40400000; rsp1_valid stays 0.
- Sub: req1 with frs1=0x40400000, frs2=0x3F800000, funct=1 -> rsp1_valid with rsp_frd=0x40000000; fu_En high for exactly 2 cycles.
- Arbitration (FADD_SCHED_RR_EN defined): both valid continuously from reset -> grant order 0,1,0,1. With the macro undefined -> grant order 0,0,0.
- Back-pressure: rsp0_ready held low for 10 cycles -> rsp0_valid and rsp_frd stable, req ready=0 and busy=1 throughout; rsp0_ready high -> IDLE next cycle, new request accepted.
- Reset: rst pulsed during EXEC -> next cycle state IDLE, all valids/readys 0, busy 0, fu_En 0; no response for the dropped op.
- Latency sweep: EXEC_CYCLES=1 and 15 -> rsp_valid at 2 and 16 clocks after accept respectively.

Source files
------------

// File: rtl/fadd_sched.sv
// fadd_sched: shares one combinational fadd_fsub between two requesters, holding operands for EXEC_CYCLES clocks.
// Optional macro FADD_SCHED_RR_EN selects round-robin arbitration; the default is fixed priority to requester 0.
module fadd_sched #(
  parameter int unsigned FLEN        = 32,
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [FLEN-1:0] req0_frs1,
  input  logic [FLEN-1:0] req0_frs2,
  input  logic            req0_funct,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [FLEN-1:0] req1_frs1,
  input  logic [FLEN-1:0] req1_frs2,
  input  logic            req1_funct,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [FLEN-1:0] rsp_frd,
  output logic            busy,
  output logic [FLEN-1:0] fu_frs1,
  output logic [FLEN-1:0] fu_frs2,
  output logic            fu_En,
  output logic            fu_funct,
  input  logic [FLEN-1:0] fu_frd
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       last_grant;
  logic       grant0;
  logic       grant1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
`ifdef FADD_SCHED_RR_EN
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`else
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
`endif
    end
  end

`ifndef FADD_SCHED_RR_EN
  // last_grant is kept up to date in both builds so the state matches across configurations.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      fu_frs1    <= '0;
      fu_frs2    <= '0;
      fu_funct   <= 1'b0;
      fu_En      <= 1'b0;
      rsp_frd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            fu_frs1    <= grant1 ? req1_frs1 : req0_frs1;
            fu_frs2    <= grant1 ? req1_frs2 : req0_frs2;
            fu_funct   <= grant1 ? req1_funct : req0_funct;
            owner      <= grant1;
            last_grant <= grant1;
            cnt        <= CNT_INIT;
            fu_En      <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_frd <= fu_frd;
            fu_En   <= 1'b0;
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
